// File: rtl/pulse_gen_moore.sv
// ---------------------------------------------------------------------------
// pulse_gen_moore
//
// Stretches single-cycle tick requests into fixed-width level pulses. After
// each pulse, the output is held low for a guaranteed minimum gap. This block
// is the inverse of the rising-edge tick detector: each accepted request comes
// back out of that detector as exactly one tick.
//
// Parameters:
//   HIGH_CYC : cycles level stays high per pulse (1 .. 2^CNT_W-1)
//   LOW_CYC  : minimum cycles level stays low after a pulse (1 .. 2^CNT_W-1)
//   CNT_W    : width of the duration counter
//   PEND_W   : width of the pending-request counter (max 2^PEND_W-1 queued)
//
// Ports:
//   clk      : single rising-edge clock
//   rst      : synchronous active-high reset, overrides any concurrent tick
//   tick     : request input; every high sample is one request
//   level    : generated pulse (registered)
//   busy     : high while a pulse or its low gap is in progress (registered)
//   pending  : number of queued requests (always 0 without the queue)
//   overflow : sticky lost-request flag, cleared only by rst
//
// Build option:
//   PULSE_GEN_QUEUE_EN : when defined, ticks arriving while busy are counted
//                        and replayed back-to-back. When undefined, those
//                        ticks are dropped and only set overflow. A tick on
//                        the final gap edge still chains a new pulse.
// ---------------------------------------------------------------------------
module pulse_gen_moore #(
    parameter int HIGH_CYC = 4,
    parameter int LOW_CYC  = 2,
    parameter int CNT_W    = 8,
    parameter int PEND_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    output logic              level,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              level_q;
    logic              busy_q;

    logic              cnt_zero;
    logic              gap_end;
    logic              busy_tick;
    logic              req_avail;

    // A tick that cannot start a pulse by itself: it lands while a pulse is
    // high, or during the gap but before its last cycle. Only the final gap
    // edge is allowed to turn a fresh tick directly into the next pulse.
    assign cnt_zero  = (cnt_q == '0);
    assign gap_end   = (state_q == ST_GAP) && cnt_zero;
    assign busy_tick = tick && ((state_q == ST_HIGH) ||
                                ((state_q == ST_GAP) && !cnt_zero));

`ifdef PULSE_GEN_QUEUE_EN

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;

    // At the end of the gap, either a queued request or a tick on that same
    // edge starts the next pulse.
    assign req_avail = gap_end && ((pend_q != '0) || tick);

    // Pending counter bookkeeping. A busy tick is queued unless the counter
    // is full, in which case it is lost and flagged. At the end of the gap a
    // queued request is consumed. A simultaneous tick takes its place, so the
    // count holds. With an empty queue, the tick itself starts the pulse
    // without touching the count.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (busy_tick) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (gap_end && (pend_q != '0) && !tick) begin
            pend_d = pend_q - PEND_ONE;
        end
    end

    // The pending register lives next to the main state but is kept separate
    // so that the queue-less build contains no trace of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;

`else

    // Without a queue, only a tick on the final gap edge can chain a pulse.
    // Any other tick seen while busy is lost.
    assign req_avail = gap_end && tick;

    // Dropped requests are remembered only through the sticky flag.
    always_comb begin
        ovf_d = ovf_q;
        if (busy_tick) begin
            ovf_d = 1'b1;
        end
    end

    assign pending = '0;

`endif

    // Next-state logic. The duration counter is loaded on entry to HIGH or
    // GAP and counts down to zero. The zero value marks the last cycle of
    // the phase. The unused encoding falls back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_HIGH;
                    cnt_d   = HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                if (cnt_zero) begin
                    state_d = ST_GAP;
                    cnt_d   = LOW_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (req_avail) begin
                    state_d = ST_HIGH;
                    cnt_d   = HIGH_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and the sticky overflow flag. Reset wins over any tick
    // that arrives on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // The outputs are decoded from the registered state and then registered
    // once more. As a result, level and busy become visible one edge after
    // the state changes, and no input can reach an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            level_q <= (state_q == ST_HIGH);
            busy_q  <= (state_q != ST_IDLE);
        end
    end

    assign level    = level_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: doc/pulse_gen_moore.md
# pulse_gen_moore

- Converts single-cycle `tick` requests into fixed-width `level` pulses: one Moore state machine, registered outputs, guaranteed minimum low gap between pulses.
- Inverse of the team's rising-edge tick detector: a tick stream through this block and then through the detector yields one tick per accepted request.
- Used wherever a one-cycle event must drive a slower level-sensitive consumer (LED strobe, handshake request line, external enable).

## Interface
- `HIGH_CYC`, default 4: cycles `level` stays high per pulse. Range 1 … 2^CNT_W−1.
- `LOW_CYC`, default 2: minimum cycles `level` stays low after a pulse. Range 1 … 2^CNT_W−1.
- `CNT_W`, default 8: width of the internal duration counter.
- `PEND_W`, default 3: width of the pending-request counter, so the maximum pending count is 2^PEND_W−1.

Ports:
- `clk` input 1: the single clock. All logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `tick` input 1: request. Sampled at every rising edge; each high sample is one request.
- `level` output 1: the generated pulse.
- `busy` output 1: high in HIGH and GAP states.
- `pending` output PEND_W: number of queued requests.
- `overflow` output 1: sticky flag, set when a request is lost.

## Operation
- States: IDLE (00), HIGH (01), GAP (10). Code 11 is illegal and goes to IDLE.
- Outputs are decoded from the registered state, so this is a Moore machine: `level` = (state==HIGH); `busy` = (state!=IDLE).
- **IDLE**:
  - `tick`=1 → HIGH, counter loaded with HIGH_CYC−1.
  - Otherwise stay in IDLE.
- **HIGH**:
  - Counter decrements each cycle.
  - At counter 0 → GAP, counter loaded with LOW_CYC−1.
- **GAP**:
  - Counter decrements each cycle.
  - At counter 0: if a request is available → HIGH (reload HIGH_CYC−1); else → IDLE.
- A request is "available" at the end of GAP when `pending`>0 (queue enabled) or `tick`=1 on that edge.
- **Tick while busy**, queue enabled:
  - `pending` increments, saturating at 2^PEND_W−1.
  - A tick arriving with `pending` at max sets `overflow`; `pending` is unchanged.
- **End of GAP with queue enabled**:
  - Consumes one pending request: `pending` decrements.
  - If `tick` is high on the same edge, `pending` is unchanged: the tick replaces the consumed request.
  - If `pending`=0 and `tick`=1, the tick itself starts the new pulse.
- `overflow` is cleared only by `rst`.
- **Reset**: every edge with `rst`=1 forces state IDLE, counter 0, `pending` 0, `overflow` 0. It overrides any concurrent `tick`, including when asserted mid-pulse or mid-gap.
- Reset values: `level`=0, `busy`=0, `pending`=0, `overflow`=0.

## Timing
- Latency: `tick` sampled high in IDLE at edge k → `level`=1 after edge k+1, held through edge k+HIGH_CYC, low after edge k+HIGH_CYC+1.
- `level` width is exactly HIGH_CYC cycles.
- The low interval between pulses is at least LOW_CYC cycles. It is exactly LOW_CYC cycles when a request is available at the end of GAP (GAP→HIGH directly).
- `busy` falls exactly HIGH_CYC+LOW_CYC cycles after it rose, unless the machine chains directly into another pulse.
- `pending` and `overflow` update on the same edge that samples `tick`.
- No combinational path from any input to any output.

## Configuration
- Macro: `PULSE_GEN_QUEUE_EN`.
- **Defined**: pending-request counter present, behaviour as above.
- **Undefined**:
  - Pending counter is removed and `pending` is tied to 0.
  - A `tick` sampled in HIGH, or in GAP before its final cycle, is dropped and sets `overflow`.
  - A `tick` on the final GAP edge still starts a new pulse.

## Test plan
- **Single request**: HIGH_CYC=4, LOW_CYC=2, one `tick` at edge 0 → `level` high after edges 1–4, low after edge 5; `busy` high after edges 1–6, low after edge 7.
- **Queued burst** (queue enabled): 3 ticks on consecutive edges 0–2 → `pending` goes 1, 2. Expect three 4-cycle pulses separated by exactly 2 low cycles; `pending` returns to 0; `overflow`=0.
- **Overflow**: PEND_W=2, 5 ticks while busy → `pending` saturates at 3 and `overflow`=1 after the 4th queued tick. Exactly 4 pulses total are then produced.
- **Queue disabled, tick held high for 20 cycles** → pulses of 4 high and 2 low repeat back-to-back; `overflow`=1 after the first tick sampled in HIGH; `pending`=0 throughout.
- **Reset mid-pulse**: `rst` asserted for one edge during HIGH counter=2 → after that edge `level`=0, `busy`=0, `pending`=0, `overflow`=0. A `tick` on the same edge is ignored.
- **Minimum config**: HIGH_CYC=1, LOW_CYC=1, `tick` every edge (queue enabled) → `level` alternates 1,0 with a period of 2 cycles; `pending` rises by 1 every second cycle until saturation.
